dmem_ctrl: RTL and testbench

Parametrised data memory for the MIPS pipeline MEM stage. It replaces the fixed 2048x32 word-only array with:
- byte-addressed access with byte, half and word sizes
- sign/zero extension on loads
- a configurable read-pipeline latency
- a valid/ready request handshake
- misalignment fault reporting
- an optional clear-on-reset sequencer

---
 rtl/dmem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed MEM-stage data memory with sized/extended loads, READ_LAT-deep read
// pipeline, valid/ready request handshake and fault reporting. Optional clear sequencer: DMEM_CLEAR_ON_RESET_EN.
module dmem_ctrl #(
    parameter int unsigned DEPTH_LOG2   = 11,
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned INIT_WORD7_8 = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DEPTH_LOG2+1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  fault,
    output logic [DEPTH_LOG2+1:0] fault_addr
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam bit PRELOAD_EN = (INIT_WORD7_8 != 0) && (DEPTH > 8);
    localparam logic [DEPTH_LOG2-1:0] IDX7 = DEPTH_LOG2'(7);
    localparam logic [DEPTH_LOG2-1:0] IDX8 = DEPTH_LOG2'(8);

    logic [31:0] mem [DEPTH];
    // 2-state so the flags start cleared at time zero; set once word 7/8 is first written
    bit   [1:0]  pre_gone;

    logic                  ready_q;
    logic                  accept, bad, store_ok, load_ok;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            offset;
    logic [31:0]           rd_word, shifted, load_data, lane_data, wr_word;
    logic [3:0]            be;
    logic                  clear_we;
    logic [DEPTH_LOG2-1:0] clear_idx;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_wa;
    logic [31:0]           mem_wd;
    logic [READ_LAT-1:0]   pipe_v;
    logic [31:0]           pipe_d [READ_LAT];

    assign req_ready = ready_q && !reset;
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[DEPTH_LOG2+1:2];
    assign offset    = req_addr[1:0];
    assign store_ok  = accept && !bad && req_we;
    assign load_ok   = accept && !bad && !req_we;

    always_comb begin
        bad = 1'b0;
        case (req_size)
            2'b01:   bad = offset[0];
            2'b10:   bad = (offset != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
    end

    // Preloaded words read as 1 until their first write; stores merge against this view.
    always_comb begin
        rd_word = mem[word_idx];
        if (PRELOAD_EN) begin
            if (word_idx == IDX7 && !pre_gone[0]) rd_word = 32'd1;
            if (word_idx == IDX8 && !pre_gone[1]) rd_word = 32'd1;
        end
    end

    always_comb begin
        be        = 4'b1111;
        lane_data = req_wdata;
        case (req_size)
            2'b00: begin
                be        = 4'b0001 << offset;
                lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << offset;
                lane_data = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        wr_word = rd_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) wr_word[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

    always_comb begin
        shifted   = rd_word >> {offset, 3'b000};
        load_data = shifted;
        case (req_size)
            2'b00:   load_data = {{24{req_signed & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{req_signed & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign mem_we = clear_we || store_ok;
    assign mem_wa = clear_we ? clear_idx : word_idx;
    assign mem_wd = clear_we ? '0 : wr_word;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
            if (mem_wa == IDX7) pre_gone[0] <= 1'b1;
            if (mem_wa == IDX8) pre_gone[1] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            fault <= accept && bad;
            if (accept && bad) fault_addr <= req_addr;
        end
    end

    // Data advances only behind a valid token, so the last stage holds between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_v <= '0;
            pipe_d <= '{default: '0};
        end else begin
            pipe_v[0] <= load_ok;
            if (load_ok) pipe_d[0] <= load_data;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign rsp_valid = pipe_v[READ_LAT-1];
    assign rsp_rdata = pipe_d[READ_LAT-1];

`ifdef DMEM_CLEAR_ON_RESET_EN
    typedef enum logic {IDLE_CLEAR, READY} state_t;
    state_t                state, state_next;
    logic [DEPTH_LOG2-1:0] clr_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE_CLEAR) clr_cnt <= clr_cnt + DEPTH_LOG2'(1);
        end
    end

    always_comb begin
        state_next = state;
        clear_we   = 1'b0;
        case (state)
            IDLE_CLEAR: begin
                clear_we = !reset;
                if (clr_cnt == '1) state_next = READY;
            end
            default: ;
        endcase
    end

    assign clear_idx = clr_cnt;
    assign ready_q   = (state == READY);
`else
    always_ff @(posedge clock) begin
        if (reset) ready_q <= 1'b0;
        else       ready_q <= 1'b1;
    end

    assign clear_we  = 1'b0;
    assign clear_idx = '0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: one stimulus stream drives a READ_LAT=1 and a READ_LAT=3 instance.
module tb_dmem_ctrl;
`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic [31:0] PRE       = 32'd0;
    localparam int          READY_CYC = 2048;
    localparam logic [31:0] POST_W20  = 32'h0000_0000;
    localparam logic [31:0] POST_W1C  = 32'h0000_0000;
`else
    localparam logic [31:0] PRE       = 32'd1;
    localparam int          READY_CYC = 1;
    localparam logic [31:0] POST_W20  = 32'hDEAD_80EF;
    localparam logic [31:0] POST_W1C  = 32'h0000_5501;
`endif
    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [12:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rdy1, rdy3, rv1, rv3, flt1, flt3;
    logic [31:0] rd1, rd3;
    logic [12:0] fa1, fa3;

    dmem_ctrl #(.DEPTH_LOG2(11), .READ_LAT(1), .INIT_WORD7_8(1)) u_lat1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .fault(flt1), .fault_addr(fa1)
    );

    dmem_ctrl #(.DEPTH_LOG2(11), .READ_LAT(3), .INIT_WORD7_8(1)) u_lat3 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy3),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .fault(flt3), .fault_addr(fa3)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        q1[$], q3[$], qf[$];
    int          cyc = 0;
    int          checks = 0, errors = 0;
    logic [31:0] last1 = '0, last3 = '0, last_fa = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (q1.size() != 0 && q1[0].due == cyc) begin
            check("rsp_valid_lat1", 32'(rv1), 32'd1);
            check("rsp_rdata_lat1", rd1, q1[0].data);
            last1 = q1[0].data;
            void'(q1.pop_front());
        end else begin
            check("rsp_idle_lat1", 32'(rv1), 32'd0);
            check("rsp_hold_lat1", rd1, last1);
        end
        if (q3.size() != 0 && q3[0].due == cyc) begin
            check("rsp_valid_lat3", 32'(rv3), 32'd1);
            check("rsp_rdata_lat3", rd3, q3[0].data);
            last3 = q3[0].data;
            void'(q3.pop_front());
        end else begin
            check("rsp_idle_lat3", 32'(rv3), 32'd0);
            check("rsp_hold_lat3", rd3, last3);
        end
        if (qf.size() != 0 && qf[0].due == cyc) begin
            check("fault_lat1", 32'(flt1), 32'd1);
            check("fault_lat3", 32'(flt3), 32'd1);
            check("fault_addr_lat1", 32'(fa1), qf[0].data);
            check("fault_addr_lat3", 32'(fa3), qf[0].data);
            last_fa = qf[0].data;
            void'(qf.pop_front());
        end else begin
            check("fault_idle_lat1", 32'(flt1), 32'd0);
            check("fault_idle_lat3", 32'(flt3), 32'd0);
            check("fault_addr_hold_lat1", 32'(fa1), last_fa);
            check("fault_addr_hold_lat3", 32'(fa3), last_fa);
        end
    end

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [12:0] addr, input logic [31:0] wdata);
        @(negedge clock);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic accept();
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic ld(input logic [1:0] size, input logic sgn, input logic [12:0] addr,
                      input logic [31:0] exp);
        drive(1'b0, size, sgn, addr, 32'h5A5A_5A5A);
        q1.push_back('{cyc + 1, exp});
        q3.push_back('{cyc + 3, exp});
        accept();
    endtask

    task automatic st(input logic [1:0] size, input logic [12:0] addr, input logic [31:0] wdata);
        drive(1'b1, size, 1'b0, addr, wdata);
        accept();
    endtask

    task automatic bad(input logic we, input logic [1:0] size, input logic [12:0] addr);
        drive(we, size, 1'b1, addr, 32'hFFFF_FFFF);
        qf.push_back('{cyc + 1, 32'(addr)});
        accept();
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        #1;
        reset = 1'b1;
        q1.delete();
        q3.delete();
        qf.delete();
        last1   = '0;
        last3   = '0;
        last_fa = '0;
        repeat (n) @(negedge clock);
        check("ready_in_reset", {30'b0, rdy3, rdy1}, 32'd0);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(rdy1 && rdy3) && n < 5000);
        check("ready_latency", n, READY_CYC);
    endtask

    initial begin
        // Initial reset, then a second reset partway through the (optional) clear sequence.
        do_reset(3);
        repeat (5) @(negedge clock);
        do_reset(2);
        wait_ready();

        ld(SW, 1'b0, 13'h01C, PRE);
        ld(SW, 1'b0, 13'h020, PRE);
        st(SB, 13'h01D, 32'h0000_0055);
        ld(SW, 1'b0, 13'h01C, 32'h0000_5500 | PRE);

        st(SW, 13'h020, 32'hDEAD_BEEF);
        ld(SW, 1'b0, 13'h020, 32'hDEAD_BEEF);
        st(SB, 13'h021, 32'h0000_AB80);
        ld(SB, 1'b1, 13'h021, 32'hFFFF_FF80);
        ld(SB, 1'b0, 13'h021, 32'h0000_0080);
        ld(SW, 1'b0, 13'h020, 32'hDEAD_80EF);
        ld(SW, 1'b1, 13'h020, 32'hDEAD_80EF);
        ld(SB, 1'b1, 13'h022, 32'hFFFF_FFAD);

        bad(1'b0, SH, 13'h023);
        bad(1'b0, SX, 13'h000);

        st(SW, 13'h024, 32'h1122_3344);
        bad(1'b1, SW, 13'h026);
        ld(SW, 1'b0, 13'h024, 32'h1122_3344);
        st(SH, 13'h026, 32'h9999_A5B6);
        ld(SW, 1'b0, 13'h024, 32'hA5B6_3344);
        ld(SH, 1'b1, 13'h026, 32'hFFFF_A5B6);
        ld(SH, 1'b0, 13'h026, 32'h0000_A5B6);
        ld(SH, 1'b1, 13'h024, 32'h0000_3344);
        ld(SB, 1'b1, 13'h027, 32'hFFFF_FFA5);
        bad(1'b1, SX, 13'h030);

        st(SW, 13'h1FFC, 32'hCAFE_F00D);
        st(SB, 13'h1FFF, 32'h0000_007E);
        ld(SW, 1'b0, 13'h1FFC, 32'h7EFE_F00D);
        ld(SB, 1'b0, 13'h1FFF, 32'h0000_007E);
        ld(SH, 1'b1, 13'h1FFE, 32'h0000_7EFE);
        bad(1'b0, SH, 13'h1FFF);
        repeat (6) @(negedge clock);

        // Reset while the READ_LAT=3 load is still in flight.
        ld(SW, 1'b0, 13'h020, 32'hDEAD_80EF);
        do_reset(2);
        wait_ready();
        repeat (4) @(negedge clock);
        ld(SW, 1'b0, 13'h020, POST_W20);
        ld(SW, 1'b0, 13'h01C, POST_W1C);
        repeat (6) @(negedge clock);

        check("scoreboard_drained", q1.size() + q3.size() + qf.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
